dmac_seq_ctrl: RTL and testbench

Job sequencer for the 16-input scaled bipolar stochastic MAC datapath. It accepts one job at a time through a valid/ready handshake and pulses operand/seed load and a datapath clear. It then runs the datapath for a programmable bitstream length and counts the ones on the MAC output bit. It returns the ones count plus a signed bipolar estimate through a second valid/ready handshake, and sits between the layer scheduler and one MAC16 instance.

---
 rtl/dmac_ctrl_pkg.sv | 21 ++
 rtl/sc_ones_cnt.sv | 27 ++
 rtl/dmac_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_dmac_seq_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_ctrl_pkg.sv
// Shared types and helpers for the stochastic MAC job sequencer.
package dmac_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    RUN,
    DONE
  } dmac_state_t;

  localparam int unsigned DMAC_CNT_W = 8;
  localparam int unsigned DMAC_LAT   = 1;

  // Bipolar estimate: 2*ones - (len+1), returned wide; callers truncate.
  function automatic logic signed [31:0] bipolar(input logic [31:0] ones,
                                                 input logic [31:0] len);
    return $signed(ones << 1) - $signed(len + 32'd1);
  endfunction

endpackage

// File: rtl/sc_ones_cnt.sv
// Clearable, enabled ones accumulator for stochastic bitstreams.
module sc_ones_cnt #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(i_bit);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmac_seq_ctrl.sv
// Job sequencer for one MAC16 stochastic datapath: load, fill, run, report.
module dmac_seq_ctrl
  import dmac_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DMAC_CNT_W,
  parameter int unsigned LAT   = DMAC_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start_valid,
  output logic                    o_start_ready,
  input  logic [CNT_W-1:0]        i_len,
  input  logic                    i_abort,
  output logic                    o_loadA,
  output logic                    o_loadB,
  output logic                    o_dp_clr,
  input  logic                    i_mac_bit,
  output logic                    o_busy,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [CNT_W:0]          o_ones,
  output logic signed [CNT_W+1:0] o_bipolar
);

  localparam int unsigned BW = CNT_W + 2;

  dmac_state_t             r_state;
  logic [CNT_W-1:0]        r_len;
  logic [CNT_W-1:0]        r_cyc;
  logic [2:0]              r_fill;
  logic signed [CNT_W+1:0] r_bip;
  logic [CNT_W:0]          w_ones;
  logic                    w_load;
  logic                    w_run;

  assign w_load = (r_state == LOAD);
  assign w_run  = (r_state == RUN);

  sc_ones_cnt #(
    .W(CNT_W + 1)
  ) u_ones (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_load),
    .i_en (w_run),
    .i_bit(i_mac_bit),
    .o_cnt(w_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cyc   <= '0;
      r_fill  <= '0;
      r_bip   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_valid) begin
            r_len   <= i_len;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else begin
            r_cyc   <= '0;
            r_fill  <= '0;
            r_state <= (LAT > 0) ? FILL : RUN;
          end
        end
        FILL: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else if ({29'd0, r_fill} == LAT - 1) begin
            r_state <= RUN;
          end else begin
            r_fill <= r_fill + 3'd1;
          end
        end
        RUN: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else begin
            // Estimate tracks the count including this cycle's bit so it is final on entry to DONE.
            r_bip <= BW'(bipolar(32'(w_ones) + 32'(i_mac_bit), 32'(r_len)));
            if (r_cyc == r_len) begin
              r_state <= DONE;
            end else begin
              r_cyc <= r_cyc + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (i_abort) begin
            r_state <= IDLE;
          end else if (i_res_ready) begin
            if (i_start_valid) begin
              r_len   <= i_len;
              r_state <= LOAD;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_start_ready = (r_state == IDLE) | ((r_state == DONE) & i_res_ready);
  assign o_loadA       = w_load;
  assign o_loadB       = w_load;
  assign o_dp_clr      = w_load;
  assign o_busy        = (r_state != IDLE);
  assign o_res_valid   = (r_state == DONE);
  assign o_ones        = w_ones;
  assign o_bipolar     = r_bip;

endmodule

// File: tb/tb_dmac_seq_ctrl.sv
// Directed, table-driven bench for dmac_seq_ctrl (CNT_W=8, LAT=1).
module tb_dmac_seq_ctrl;

  localparam int CNT_W = 8;
  localparam int LAT   = 1;

  logic                    clk;
  logic                    rst;
  logic                    i_start_valid;
  logic                    o_start_ready;
  logic [CNT_W-1:0]        i_len;
  logic                    i_abort;
  logic                    o_loadA;
  logic                    o_loadB;
  logic                    o_dp_clr;
  logic                    i_mac_bit;
  logic                    o_busy;
  logic                    o_res_valid;
  logic                    i_res_ready;
  logic [CNT_W:0]          o_ones;
  logic signed [CNT_W+1:0] o_bipolar;

  int n_checks = 0;
  int n_errors = 0;

  dmac_seq_ctrl #(
    .CNT_W(CNT_W),
    .LAT  (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start_valid(i_start_valid),
    .o_start_ready(o_start_ready),
    .i_len        (i_len),
    .i_abort      (i_abort),
    .o_loadA      (o_loadA),
    .o_loadB      (o_loadB),
    .o_dp_clr     (o_dp_clr),
    .i_mac_bit    (i_mac_bit),
    .o_busy       (o_busy),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_ones       (o_ones),
    .o_bipolar    (o_bipolar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic        fill1;
    logic [15:0] pat;
    int          exp_ones;
    int          exp_bip;
    int          exp_cyc;
  } job_vec_t;

  job_vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit presented before edge e (acceptance edge = 0); RUN bit k is sampled at edge LAT+2+k.
  function automatic logic mac_for(input int e, input int len, input logic fill1,
                                   input logic [15:0] pat);
    int k;
    k = e - LAT - 2;
    if (k >= 0 && k <= len) return fill1 ? 1'b1 : pat[k];
    return 1'b1;
  endfunction

  // Called #1 after the accepting edge; returns with the DUT in DONE (or after a timeout).
  task automatic job_body(input int len, input logic fill1, input logic [15:0] pat,
                          input int exp_ones, input int exp_bip, input int exp_cyc);
    int e;
    bit seen;
    chk("load_strobes_on", {29'd0, o_loadA, o_loadB, o_dp_clr}, 7);
    chk("busy_in_load", int'(o_busy), 1);
    i_mac_bit = mac_for(1, len, fill1, pat);
    e = 0;
    seen = 1'b0;
    while (!seen && e < 600) begin
      tick();
      e++;
      if (e == 1) chk("load_strobes_off", {29'd0, o_loadA, o_loadB, o_dp_clr}, 0);
      if (o_res_valid) seen = 1'b1;
      else i_mac_bit = mac_for(e + 1, len, fill1, pat);
    end
    if (!seen) begin
      chk("res_valid_timeout", 0, 1);
    end else begin
      chk("res_latency_cycle", e + 1, exp_cyc);
      chk("ones", int'(o_ones), exp_ones);
      chk("bipolar", int'($signed(o_bipolar)), exp_bip);
    end
  endtask

  task automatic accept(input int len);
    i_len = CNT_W'(len);
    i_start_valid = 1'b1;
    chk("start_ready_idle", int'(o_start_ready), 1);
    tick();
    i_start_valid = 1'b0;
  endtask

  task automatic consume();
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk("idle_after_consume_busy", int'(o_busy), 0);
    chk("idle_after_consume_valid", int'(o_res_valid), 0);
  endtask

  initial begin
    vecs[0] = '{len: 255, fill1: 1'b1, pat: 16'h0000, exp_ones: 256, exp_bip: 256,  exp_cyc: 259};
    vecs[1] = '{len: 3,   fill1: 1'b0, pat: 16'h000D, exp_ones: 3,   exp_bip: 2,    exp_cyc: 7};
    vecs[2] = '{len: 0,   fill1: 1'b0, pat: 16'h0000, exp_ones: 0,   exp_bip: -1,   exp_cyc: 4};
    vecs[3] = '{len: 7,   fill1: 1'b0, pat: 16'h00F0, exp_ones: 4,   exp_bip: 0,    exp_cyc: 11};
    vecs[4] = '{len: 15,  fill1: 1'b0, pat: 16'h0001, exp_ones: 1,   exp_bip: -14,  exp_cyc: 19};
    vecs[5] = '{len: 1,   fill1: 1'b0, pat: 16'hFFFF, exp_ones: 2,   exp_bip: 2,    exp_cyc: 5};

    rst = 1'b1;
    i_start_valid = 1'b0;
    i_len = '0;
    i_abort = 1'b0;
    i_mac_bit = 1'b0;
    i_res_ready = 1'b0;
    tick();
    tick();
    chk("rst_loads", {29'd0, o_loadA, o_loadB, o_dp_clr}, 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(o_res_valid), 0);
    chk("rst_ones", int'(o_ones), 0);
    chk("rst_bipolar", int'($signed(o_bipolar)), 0);
    chk("rst_start_ready", int'(o_start_ready), 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].len);
      job_body(vecs[i].len, vecs[i].fill1, vecs[i].pat,
               vecs[i].exp_ones, vecs[i].exp_bip, vecs[i].exp_cyc);
      consume();
    end

    // Backpressure for 10 cycles, then result handshake and new job in the same edge.
    accept(3);
    job_body(3, 1'b0, 16'h000D, 3, 2, 7);
    for (int c = 0; c < 10; c++) begin
      i_mac_bit = c[0];
      tick();
      chk("bp_valid", int'(o_res_valid), 1);
      chk("bp_ones", int'(o_ones), 3);
      chk("bp_bipolar", int'($signed(o_bipolar)), 2);
    end
    chk("bp_start_ready_low", int'(o_start_ready), 0);
    i_len = '0;
    i_start_valid = 1'b1;
    i_res_ready = 1'b1;
    #1;
    chk("b2b_start_ready", int'(o_start_ready), 1);
    tick();
    i_start_valid = 1'b0;
    i_res_ready = 1'b0;
    chk("b2b_no_valid", int'(o_res_valid), 0);
    job_body(0, 1'b0, 16'h0000, 0, -1, 4);
    consume();

    // Abort in the middle of RUN, then a fresh job.
    accept(20);
    i_mac_bit = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("abort_pre_busy", int'(o_busy), 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_run_busy", int'(o_busy), 0);
    chk("abort_run_valid", int'(o_res_valid), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_run_no_result", int'(o_res_valid | o_busy), 0);
    end
    accept(3);
    job_body(3, 1'b0, 16'h000D, 3, 2, 7);
    consume();

    // Abort in DONE with a job offered: job must be dropped.
    accept(0);
    job_body(0, 1'b0, 16'h0001, 1, 1, 4);
    i_abort = 1'b1;
    i_start_valid = 1'b1;
    i_res_ready = 1'b1;
    tick();
    i_abort = 1'b0;
    i_start_valid = 1'b0;
    i_res_ready = 1'b0;
    chk("abort_done_busy", int'(o_busy), 0);
    chk("abort_done_load", int'(o_loadA), 0);
    chk("abort_done_valid", int'(o_res_valid), 0);
    tick();
    chk("abort_done_still_idle", int'(o_busy), 0);

    // Asynchronous reset during FILL.
    accept(5);
    tick();
    chk("fill_busy", int'(o_busy), 1);
    chk("fill_bipolar_stale", int'($signed(o_bipolar)), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_loads", {29'd0, o_loadA, o_loadB, o_dp_clr}, 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_valid", int'(o_res_valid), 0);
    chk("arst_ones", int'(o_ones), 0);
    chk("arst_bipolar", int'($signed(o_bipolar)), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_start_ready", int'(o_start_ready), 1);
    chk("post_rst_busy", int'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
